cp0_exception_unit: RTL

MEM-stage coprocessor-0 block. It collects per-instruction exception flags and hardware interrupts, and resolves them by priority into one exception code. It owns the CP0 registers (BadVAddr, Count, Compare, Status, Cause, EPC, EBase). It drives the exception code, EPC and EBase into the pipeline control unit, which returns the flush and handler address.

---
 rtl/cp0_exception_unit.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/cp0_exception_unit.sv
// cp0_exception_unit
// MEM-stage coprocessor-0 block. It prioritises the MEM instruction's
// exception flags and pending interrupts into a single exception code. It
// holds BadVAddr, Count, Compare, Status, Cause, EPC and EBase, and updates
// them when an exception or eret retires.
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   mem_*_i                   MEM-stage instruction info and exception flags
//   hw_int_i                  level-sensitive hardware interrupt lines
//   cp0_we/waddr/wsel/wdata_i WB-stage write to a CP0 register
//   cp0_raddr/rsel_i          read select; cp0_rdata_o (combinational)
//   exceptionType_o           resolved exception code (combinational)
//   CP0_epc_o, CP0_ebase_o    handler/return info for pipeline control
//   timer_int_o               Count/Compare timer interrupt pending
//
// Optional feature: define CP0_TIMER_EN to build Count/Compare and the timer
// interrupt. Without it, Count and Compare read 0 and the timer never fires.
module cp0_exception_unit #(
  parameter logic [31:0] EBASE_RESET = 32'h80000000,
  parameter int unsigned HW_INT_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_valid_i,
  input  logic                mem_stall_i,
  input  logic [31:0]         mem_pc_i,
  input  logic                mem_in_delay_slot_i,
  input  logic [7:0]          mem_exc_flags_i,
  input  logic [31:0]         mem_bad_vaddr_i,
  input  logic [HW_INT_W-1:0] hw_int_i,
  input  logic                cp0_we_i,
  input  logic [4:0]          cp0_waddr_i,
  input  logic [2:0]          cp0_wsel_i,
  input  logic [31:0]         cp0_wdata_i,
  input  logic [4:0]          cp0_raddr_i,
  input  logic [2:0]          cp0_rsel_i,
  output logic [31:0]         cp0_rdata_o,
  output logic [31:0]         exceptionType_o,
  output logic [31:0]         CP0_epc_o,
  output logic [31:0]         CP0_ebase_o,
  output logic                timer_int_o
);

  localparam logic [7:0] EXC_INT  = 8'h01;
  localparam logic [7:0] EXC_ADEL = 8'h04;
  localparam logic [7:0] EXC_ADES = 8'h05;
  localparam logic [7:0] EXC_SYS  = 8'h08;
  localparam logic [7:0] EXC_BP   = 8'h09;
  localparam logic [7:0] EXC_RI   = 8'h0a;
  localparam logic [7:0] EXC_OV   = 8'h0c;
  localparam logic [7:0] EXC_ERET = 8'h0e;

  typedef enum logic [1:0] {BADV_NONE, BADV_PC, BADV_ADDR} badv_src_e;

  logic        status_ie_q, status_ie_d;
  logic        status_exl_q, status_exl_d;
  logic [7:0]  status_im_q, status_im_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_hw_q, cause_ip_hw_d;
  logic [1:0]  cause_ip_sw_q, cause_ip_sw_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [17:0] ebase_q, ebase_d;
  logic [31:0] count_q, compare_q;
  logic        timer_q;

  logic [7:0]  cause_ip;
  logic        int_pending;
  logic [7:0]  exc_code;
  badv_src_e   badv_src;
  logic        exc_take, exc_eret;
  logic        wr_badv, wr_status, wr_cause, wr_epc, wr_ebase;

  assign wr_badv   = cp0_we_i && (cp0_waddr_i == 5'd8)  && (cp0_wsel_i == 3'd0);
  assign wr_status = cp0_we_i && (cp0_waddr_i == 5'd12) && (cp0_wsel_i == 3'd0);
  assign wr_cause  = cp0_we_i && (cp0_waddr_i == 5'd13) && (cp0_wsel_i == 3'd0);
  assign wr_epc    = cp0_we_i && (cp0_waddr_i == 5'd14) && (cp0_wsel_i == 3'd0);
  assign wr_ebase  = cp0_we_i && (cp0_waddr_i == 5'd15) && (cp0_wsel_i == 3'd1);

`ifdef CP0_TIMER_EN
  logic        wr_count, wr_compare;
  logic [31:0] count_d, compare_d;
  logic        timer_d;

  assign wr_count   = cp0_we_i && (cp0_waddr_i == 5'd9)  && (cp0_wsel_i == 3'd0);
  assign wr_compare = cp0_we_i && (cp0_waddr_i == 5'd11) && (cp0_wsel_i == 3'd0);

  always_comb begin
    count_d   = wr_count   ? cp0_wdata_i : count_q + 32'd1;
    compare_d = wr_compare ? cp0_wdata_i : compare_q;
    timer_d   = timer_q;
    // Compare write acknowledges the timer and beats a coincident match.
    if (wr_compare)
      timer_d = 1'b0;
    else if ((count_q == compare_q) && (compare_q != 32'd0))
      timer_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q   <= '0;
      compare_q <= '0;
      timer_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      timer_q   <= timer_d;
    end
  end
`else
  assign count_q   = '0;
  assign compare_q = '0;
  assign timer_q   = 1'b0;
`endif

  assign cause_ip    = {cause_ip_hw_q[5] | timer_q, cause_ip_hw_q[4:0], cause_ip_sw_q};
  assign int_pending = status_ie_q && !status_exl_q && ((cause_ip & status_im_q) != 8'd0);

  always_comb begin
    exc_code = 8'h00;
    badv_src = BADV_NONE;
    if (mem_valid_i && !mem_stall_i) begin
      if (int_pending)             exc_code = EXC_INT;
      else if (mem_exc_flags_i[0]) begin exc_code = EXC_ADEL; badv_src = BADV_PC;   end
      else if (mem_exc_flags_i[1]) exc_code = EXC_RI;
      else if (mem_exc_flags_i[2]) exc_code = EXC_OV;
      else if (mem_exc_flags_i[3]) exc_code = EXC_SYS;
      else if (mem_exc_flags_i[4]) exc_code = EXC_BP;
      else if (mem_exc_flags_i[6]) begin exc_code = EXC_ADEL; badv_src = BADV_ADDR; end
      else if (mem_exc_flags_i[7]) begin exc_code = EXC_ADES; badv_src = BADV_ADDR; end
      else if (mem_exc_flags_i[5]) exc_code = EXC_ERET;
    end
  end

  assign exc_eret = (exc_code == EXC_ERET);
  assign exc_take = (exc_code != 8'h00) && !exc_eret;

  // Software writes land first; an exception or eret then overrides the
  // fields it owns.
  always_comb begin
    status_ie_d   = status_ie_q;
    status_exl_d  = status_exl_q;
    status_im_d   = status_im_q;
    cause_bd_d    = cause_bd_q;
    cause_ip_hw_d = hw_int_i[5:0];
    cause_ip_sw_d = cause_ip_sw_q;
    cause_exc_d   = cause_exc_q;
    epc_d         = epc_q;
    badvaddr_d    = badvaddr_q;
    ebase_d       = ebase_q;

    if (wr_status) begin
      status_ie_d  = cp0_wdata_i[0];
      status_exl_d = cp0_wdata_i[1];
      status_im_d  = cp0_wdata_i[15:8];
    end
    if (wr_cause) cause_ip_sw_d = cp0_wdata_i[9:8];
    if (wr_epc)   epc_d         = cp0_wdata_i;
    if (wr_badv)  badvaddr_d    = cp0_wdata_i;
    if (wr_ebase) ebase_d       = cp0_wdata_i[29:12];

    if (exc_take) begin
      cause_exc_d = (exc_code == EXC_INT) ? 5'd0 : exc_code[4:0];
      // Nested exceptions keep the original return point.
      if (!status_exl_q) begin
        epc_d      = mem_in_delay_slot_i ? (mem_pc_i - 32'd4) : mem_pc_i;
        cause_bd_d = mem_in_delay_slot_i;
      end
      status_exl_d = 1'b1;
      if (badv_src == BADV_PC)        badvaddr_d = mem_pc_i;
      else if (badv_src == BADV_ADDR) badvaddr_d = mem_bad_vaddr_i;
    end else if (exc_eret) begin
      status_exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      status_ie_q   <= 1'b0;
      status_exl_q  <= 1'b0;
      status_im_q   <= '0;
      cause_bd_q    <= 1'b0;
      cause_ip_hw_q <= '0;
      cause_ip_sw_q <= '0;
      cause_exc_q   <= '0;
      epc_q         <= '0;
      badvaddr_q    <= '0;
      ebase_q       <= EBASE_RESET[29:12];
    end else begin
      status_ie_q   <= status_ie_d;
      status_exl_q  <= status_exl_d;
      status_im_q   <= status_im_d;
      cause_bd_q    <= cause_bd_d;
      cause_ip_hw_q <= cause_ip_hw_d;
      cause_ip_sw_q <= cause_ip_sw_d;
      cause_exc_q   <= cause_exc_d;
      epc_q         <= epc_d;
      badvaddr_q    <= badvaddr_d;
      ebase_q       <= ebase_d;
    end
  end

  always_comb begin
    cp0_rdata_o = 32'd0;
    case ({cp0_raddr_i, cp0_rsel_i})
      {5'd8,  3'd0}: cp0_rdata_o = badvaddr_q;
      {5'd9,  3'd0}: cp0_rdata_o = count_q;
      {5'd11, 3'd0}: cp0_rdata_o = compare_q;
      {5'd12, 3'd0}: cp0_rdata_o = {16'd0, status_im_q, 6'd0, status_exl_q, status_ie_q};
      {5'd13, 3'd0}: cp0_rdata_o = {cause_bd_q, 15'd0, cause_ip, 1'b0, cause_exc_q, 2'b00};
      {5'd14, 3'd0}: cp0_rdata_o = epc_q;
      {5'd15, 3'd1}: cp0_rdata_o = {2'b10, ebase_q, 12'd0};
      default:       cp0_rdata_o = 32'd0;
    endcase
  end

  assign exceptionType_o = {24'd0, exc_code};
  // Bypass so an eret right behind mtc0 EPC returns to the new address.
  assign CP0_epc_o       = wr_epc ? cp0_wdata_i : epc_q;
  assign CP0_ebase_o     = {2'b10, ebase_q, 12'd0};
  assign timer_int_o     = timer_q;

endmodule
